// File: rtl/ps2_rx_buf_pkg.sv
// Shared PS/2 receive definitions: frame geometry, FSM state encoding,
// packed frame layout and the odd-parity check.
// Latency: n/a (types and constants only). Backpressure: n/a.
package ps2_rx_buf_pkg;

    // Wire frame: start, 8 data bits LSB first, parity, stop.
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;
    // The start bit is consumed in IDLE, so only the rest is shifted.
    localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    // Layout of the shift register once a frame has been shifted in
    // LSB-first: stop ends up in the MSB and data in the low byte.
    typedef struct packed {
        logic                     stop;
        logic                     parity;
        logic [PS2_DATA_BITS-1:0] data;
    } ps2_frame_t;

    // PS/2 uses odd parity: data plus parity bit must have odd weight.
    function automatic logic ps2_parity_ok(input ps2_frame_t f);
        return ^{f.data, f.parity};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Byte FIFO, first-word-fall-through: head byte shown on dout while valid.
// Latency: a write is visible on valid/dout/count the cycle after wr_en.
// Backpressure: writes are refused when full unless a read frees a slot in the same cycle.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   wr_en, din         push a byte (dropped if full and no simultaneous read)
//   rd_en              pop the head (ignored when empty)
//   dout, valid        head byte (0 when empty), not-empty flag
//   full, count        full flag, occupancy 0..DEPTH
module ps2_rx_fifo
    import ps2_rx_buf_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [PS2_DATA_BITS-1:0] din,
    output logic [PS2_DATA_BITS-1:0] dout,
    output logic                     valid,
    output logic                     full,
    output logic [CW-1:0]            count
);

    localparam int AW = $clog2(DEPTH);

    logic [PS2_DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;

    logic w_do_rd;
    logic w_do_wr;

    assign valid = (r_count != '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;

    assign w_do_rd = rd_en & valid;
    // A full FIFO can still accept when the head is popped in the same cycle.
    assign w_do_wr = wr_en & (~full | w_do_rd);

    // Storage is not reset: contents are only observable through valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout = valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/ps2_rx_buf.sv
// PS/2 keyboard receiver: glitch-filtered clock, 11-bit frame checker, watchdog, byte FIFO.
// Latency: byte written 1 cycle after the stop-bit falling edge; valid/count update the cycle after.
// Backpressure: none toward the keyboard; a good byte arriving at a full FIFO is dropped and flagged.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   ps2c, ps2d                   raw PS/2 clock and data pins
//   rx_en                        permits a new frame to start
//   rd_en                        pops the FIFO head
//   dout, valid, full, count     FIFO head byte and status
//   rx_done_tick                 pulse: good byte queued
//   parity_err, frame_err        pulse: frame dropped (bad parity / stop bit 0)
//   timeout_err                  pulse: stalled frame aborted
//   overflow, err_clr            sticky dropped-byte flag and its clear
module ps2_rx_buf
    import ps2_rx_buf_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ps2c,
    input  logic                     ps2d,
    input  logic                     rx_en,
    input  logic                     rd_en,
    output logic [PS2_DATA_BITS-1:0] dout,
    output logic                     valid,
    output logic                     full,
    output logic [CW-1:0]            count,
    output logic                     rx_done_tick,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     timeout_err,
    output logic                     overflow,
    input  logic                     err_clr
);

    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BCW = $clog2(PS2_SHIFT_BITS);

    localparam logic [WDW-1:0] WD_LAST     = WDW'(TIMEOUT_CYC - 1);
    localparam logic [BCW-1:0] BITCNT_INIT = BCW'(PS2_SHIFT_BITS - 1);

    // ---------------------------------------------------------------
    // Clock glitch filter and falling-edge detect
    // ---------------------------------------------------------------
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk;
    logic [FILTER_LEN-1:0] w_filt_nxt;
    logic                  w_fclk_nxt;
    logic                  w_fall;

    assign w_filt_nxt = {ps2c, r_filt[FILTER_LEN-1:1]};

    // Hysteresis: the filtered clock only moves once the whole window agrees.
    always_comb begin
        w_fclk_nxt = r_fclk;
        if (&w_filt_nxt) begin
            w_fclk_nxt = 1'b1;
        end else if (~|w_filt_nxt) begin
            w_fclk_nxt = 1'b0;
        end
    end

    // Looks one cycle ahead so the edge pulse lines up with the data sample.
    assign w_fall = r_fclk & ~w_fclk_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= '1;
            r_fclk <= 1'b1;
        end else begin
            r_filt <= w_filt_nxt;
            r_fclk <= w_fclk_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Data synchroniser
    // ---------------------------------------------------------------
    logic [1:0] r_d_sync;
    logic       w_din;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d_sync <= 2'b11;
        end else begin
            r_d_sync <= {r_d_sync[0], ps2d};
        end
    end

    assign w_din = r_d_sync[1];

    // ---------------------------------------------------------------
    // Frame FSM and watchdog
    // ---------------------------------------------------------------
    ps2_state_e                r_state;
    ps2_state_e                w_state_nxt;
    logic [PS2_SHIFT_BITS-1:0] r_shift;
    logic [PS2_SHIFT_BITS-1:0] w_shift_nxt;
    logic [BCW-1:0]            r_bitcnt;
    logic [BCW-1:0]            w_bitcnt_nxt;
    logic [WDW-1:0]            r_wdog;
    logic [WDW-1:0]            w_wdog_nxt;
    logic                      r_overflow;

    ps2_frame_t w_frame;
    logic       w_fifo_wr;
    logic       w_ovf_set;
    logic       w_rx_done;
    logic       w_par_err;
    logic       w_frm_err;
    logic       w_to_err;

    assign w_frame = ps2_frame_t'(r_shift);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_wdog   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_wdog   <= w_wdog_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_wdog_nxt   = r_wdog;
        w_fifo_wr    = 1'b0;
        w_ovf_set    = 1'b0;
        w_rx_done    = 1'b0;
        w_par_err    = 1'b0;
        w_frm_err    = 1'b0;
        w_to_err     = 1'b0;

        case (r_state)
            IDLE: begin
                // A high data bit on a falling edge is not a start bit; ignore it.
                if (w_fall && rx_en && !w_din) begin
                    w_shift_nxt  = '0;
                    w_bitcnt_nxt = BITCNT_INIT;
                    w_wdog_nxt   = '0;
                    w_state_nxt  = SHIFT;
                end
            end

            SHIFT: begin
                if (w_fall) begin
                    w_shift_nxt = {w_din, r_shift[PS2_SHIFT_BITS-1:1]};
                    w_wdog_nxt  = '0;
                    if (r_bitcnt == '0) begin
                        w_state_nxt = CHECK;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt - 1'b1;
                    end
                end else if (r_wdog == WD_LAST) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end

            CHECK: begin
                // Priority frame > parity > overflow: at most one error per frame.
                w_state_nxt = IDLE;
                w_wdog_nxt  = '0;
                if (!w_frame.stop) begin
                    w_frm_err = 1'b1;
                end else if (!ps2_parity_ok(w_frame)) begin
                    w_par_err = 1'b1;
                end else if (full && !rd_en) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_fifo_wr = 1'b1;
                    w_rx_done = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A new overflow beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (err_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Byte FIFO
    // ---------------------------------------------------------------
    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_fifo_wr),
        .rd_en   (rd_en),
        .din     (w_frame.data),
        .dout    (dout),
        .valid   (valid),
        .full    (full),
        .count   (count)
    );

    assign rx_done_tick = w_rx_done;
    assign parity_err   = w_par_err;
    assign frame_err    = w_frm_err;
    assign timeout_err  = w_to_err;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_ps2_rx_buf.sv
// Directed bench for ps2_rx_buf: good/bad frames, FIFO fill/overflow, glitches,
// watchdog timing, mid-frame reset and rx_en gating.
// Inputs are driven 1 time unit after posedge; pulses are counted at negedge.
module tb_ps2_rx_buf;

    localparam int FL   = 8;
    localparam int FD   = 4;
    localparam int TO   = 100;
    localparam int CW   = 3;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       full;
    logic [CW-1:0] count;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_err;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_rx_buf #(
        .FILTER_LEN  (FL),
        .FIFO_DEPTH  (FD),
        .TIMEOUT_CYC (TO),
        .CW          (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_en        (rx_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .valid        (valid),
        .full         (full),
        .count        (count),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err),
        .overflow     (overflow),
        .err_clr      (err_clr)
    );

    int cyc_no = 0;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    int n_done = 0, n_perr = 0, n_ferr = 0, n_to = 0;
    int t_done = 0, t_to = 0, t_low = 0;

    always @(negedge clk) begin
        if (rx_done_tick) begin n_done++; t_done = cyc_no; end
        if (parity_err)   n_perr++;
        if (frame_err)    n_ferr++;
        if (timeout_err)  begin n_to++; t_to = cyc_no; end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // {stop, parity, data, start}; parity is odd unless pflip.
    function automatic logic [10:0] mkf(input logic [7:0] d, input bit pflip, input logic stop);
        logic p;
        p = (~^d) ^ pflip;
        return {stop, p, d, 1'b0};
    endfunction

    // Sends the first nbits of a frame LSB first. The fall for a bit is seen
    // FL-1 cycles after ps2c is driven low (t_low), CHECK is the cycle after.
    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input int drop_en_at, input bit rd_at_check);
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_en_at) rx_en = 1'b0;
            ps2d = bits[i];
            ps2c = 1'b1;
            step(HALF);
            ps2c = 1'b0;
            t_low = cyc_no;
            if (rd_at_check && i == nbits - 1) begin
                step(FL);
                rd_en = 1'b1;
                step(1);
                rd_en = 1'b0;
                step(HALF - FL - 1);
            end else begin
                step(HALF);
            end
        end
        ps2c = 1'b1;
        ps2d = 1'b1;
        step(HALF);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(mkf(d, 1'b0, 1'b1), 11, 99, 1'b0);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_dout"}, 32'(dout), 32'(exp));
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    int d0, p0, f0, to0;

    initial begin
        // Reset state
        step(3);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_pulses", 32'({rx_done_tick, parity_err, frame_err, timeout_err}), 0);
        reset_n = 1'b1;
        step(HALF);

        // Good byte 0x1C, latency and pop
        d0 = n_done;
        send_byte(8'h1C);
        chk("b1c_done_n", 32'(n_done - d0), 1);
        chk("b1c_latency", 32'(t_done - t_low), 32'(FL));
        chk("b1c_valid", 32'(valid), 1);
        chk("b1c_dout", 32'(dout), 32'h1C);
        chk("b1c_count", 32'(count), 1);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        chk("pop_valid", 32'(valid), 0);
        chk("pop_dout", 32'(dout), 0);

        // Parity and stop errors
        p0 = n_perr;
        f0 = n_ferr;
        d0 = n_done;
        send_bits(mkf(8'h5A, 1'b1, 1'b1), 11, 99, 1'b0);
        chk("par_n", 32'(n_perr - p0), 1);
        chk("par_count", 32'(count), 0);
        send_bits(mkf(8'hF0, 1'b0, 1'b0), 11, 99, 1'b0);
        chk("frm_n", 32'(n_ferr - f0), 1);
        send_bits(mkf(8'hF0, 1'b1, 1'b0), 11, 99, 1'b0);
        chk("frm_prio_n", 32'(n_ferr - f0), 2);
        chk("frm_prio_par", 32'(n_perr - p0), 1);
        chk("err_no_done", 32'(n_done - d0), 0);
        chk("err_valid", 32'(valid), 0);

        // Fill to full, then overflow
        d0 = n_done;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
        chk("fill_ovf", 32'(overflow), 0);
        send_byte(8'h05);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_done_n", 32'(n_done - d0), 4);
        for (int i = 1; i <= 4; i++) pop_chk("drain", 8'(i));
        chk("drain_empty", 32'(valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // Full FIFO with a read in the CHECK cycle accepts the byte
        d0 = n_done;
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
        send_bits(mkf(8'h15, 1'b0, 1'b1), 11, 99, 1'b1);
        chk("fr_count", 32'(count), 4);
        chk("fr_full", 32'(full), 1);
        chk("fr_ovf", 32'(overflow), 0);
        chk("fr_done_n", 32'(n_done - d0), 5);
        for (int i = 0; i < 4; i++) pop_chk("fr_drain", 8'h12 + 8'(i));

        // Short ps2c glitches with data low must not start a frame
        d0 = n_done; p0 = n_perr; f0 = n_ferr; to0 = n_to;
        ps2d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2c = 1'b0;
            step(3);
            ps2c = 1'b1;
            step(20);
        end
        ps2d = 1'b1;
        step(TO + 20);
        chk("glitch_quiet", 32'(n_done + n_perr + n_ferr + n_to), 32'(d0 + p0 + f0 + to0));

        // Stalled frame after 4 bits: watchdog fires TO cycles after last fall
        send_bits(mkf(8'h3C, 1'b0, 1'b1), 4, 99, 1'b0);
        for (int w = 0; w < 300 && n_to == to0; w++) step(1);
        chk("to_n", 32'(n_to - to0), 1);
        chk("to_latency", 32'(t_to - t_low), 32'(FL - 1 + TO));
        chk("to_no_done", 32'(n_done - d0), 0);
        send_byte(8'h3C);
        chk("post_to_done", 32'(n_done - d0), 1);
        chk("post_to_errs", 32'(n_perr + n_ferr), 32'(p0 + f0));
        pop_chk("post_to", 8'h3C);

        // Asynchronous reset mid-frame
        send_byte(8'h77);
        chk("pre_rst_valid", 32'(valid), 1);
        send_bits(mkf(8'h55, 1'b0, 1'b1), 5, 99, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_dout", 32'(dout), 0);
        step(2);
        reset_n = 1'b1;
        step(HALF);
        d0 = n_done;
        send_byte(8'hAA);
        chk("aa_done_n", 32'(n_done - d0), 1);
        chk("aa_count", 32'(count), 1);
        pop_chk("aa", 8'hAA);

        // rx_en gating
        d0 = n_done;
        rx_en = 1'b0;
        send_byte(8'h33);
        chk("rxen_off_done", 32'(n_done - d0), 0);
        chk("rxen_off_valid", 32'(valid), 0);
        rx_en = 1'b1;
        send_bits(mkf(8'h44, 1'b0, 1'b1), 11, 3, 1'b0);
        rx_en = 1'b1;
        chk("rxen_drop_done", 32'(n_done - d0), 1);
        pop_chk("rxen_drop", 8'h44);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_buf.md
Name: ps2_rx_buf

Overview:
- Parametrised successor to the team's single-byte PS/2 receiver.
- Filters the PS/2 clock with a configurable filter length and detects falling edges.
- Deserialises 11-bit frames and checks the start, parity and stop bits.
- Aborts stalled frames on a watchdog timeout.
- Queues good bytes in a first-word-fall-through (FWFT) FIFO, read with a valid/read handshake.
- Sits between the keyboard pins and the CPU-side MMIO keyboard register.

Parameters:
- FILTER_LEN, 8: ps2c glitch-filter length in clk cycles, minimum 2.
- FIFO_DEPTH, 16: byte FIFO depth, power of two, minimum 2.
- TIMEOUT_CYC, 50000: clk cycles without a falling edge mid-frame before the frame is aborted.
- CW, $clog2(FIFO_DEPTH)+1: width of the count output (derived).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2c  in  1  raw PS/2 clock pin.
- ps2d  in  1  raw PS/2 data pin.
- rx_en  in  1  allows a new frame to start; a frame already in progress always completes.
- rd_en  in  1  pops the FIFO head; ignored when empty.
- dout  out  8  FIFO head byte; 0 when empty.
- valid  out  1  FIFO not empty.
- full  out  1  FIFO full.
- count  out  CW  FIFO occupancy, 0..FIFO_DEPTH.
- rx_done_tick  out  1  one-cycle pulse when a good byte is written to the FIFO.
- parity_err  out  1  one-cycle pulse: frame dropped, bad parity.
- frame_err  out  1  one-cycle pulse: frame dropped, stop bit was 0.
- timeout_err  out  1  one-cycle pulse: frame aborted by the watchdog.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- err_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset values:
  - All outputs 0; count 0.
  - Filter register all-ones; filtered clock 1.
  - FSM in IDLE.
  - ps2d synchroniser (2 flops) set to 1.
  - Applies immediately and asynchronously, including mid-frame; no partial byte survives reset.
- Clock filter:
  - Each cycle, shift raw ps2c into a FILTER_LEN-bit register.
  - Filtered clock becomes 1 when the register is all-ones and 0 when it is all-zeros; otherwise it holds.
  - fall = filtered clock currently 1 AND next value 0. This gives a one-cycle pulse.
- Data sampling:
  - ps2d passes through a 2-flop synchroniser.
  - The synchronised value is sampled in the cycle fall is high.
- FSM:
  - IDLE: on fall & rx_en, if sampled data = 0 (valid start bit), clear the 10-bit shift register, set bit counter to 9, clear the watchdog and go to SHIFT. If sampled data = 1, ignore the edge and stay in IDLE.
  - SHIFT: on fall, shift sampled data in LSB-first (8 data, then parity, then stop) and clear the watchdog. If the counter is 0, go to CHECK; else decrement it. With no fall, the watchdog increments; at TIMEOUT_CYC-1 pulse timeout_err and go to IDLE. rx_en is ignored in SHIFT.
  - CHECK (exactly 1 cycle), always returns to IDLE:
    - If stop = 0: pulse frame_err only.
    - Else if XOR(data, parity) = 0 (even weight, so odd parity failed): pulse parity_err only.
    - Else if the FIFO is full and rd_en is low: set overflow and drop the byte.
    - Else write the byte and pulse rx_done_tick.
- Latency: the byte is written at the clk edge ending CHECK, i.e. 1 cycle after the stop-bit fall. valid and the updated count are visible the cycle after that.
- FIFO:
  - FWFT: dout = mem[rd_ptr] whenever valid.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is tracked separately.
  - Simultaneous write and rd_en: both happen and count is unchanged. This is legal when full (slot freed the same cycle) and when empty (the read is ignored, the write lands, count becomes 1).
- Overflow: stays set until err_clr. If err_clr and a new overflow event occur in the same cycle, overflow stays 1.
- Error priority: at most one error pulse per frame, in the order frame > parity > overflow.

Decomposition:
- Shared include ps2_defs.vh holds:
  - FSM state encodings IDLE/SHIFT/CHECK (2 bits).
  - Frame constants: PS2_FRAME_BITS = 11, PS2_DATA_BITS = 8.
  - Odd-parity convention.
- One sub-module ps2_rx_fifo(DEPTH): synchronous FWFT FIFO with wr_en, rd_en, din, dout, valid, full, count; same clk/reset_n.
- The filter, synchroniser, FSM and watchdog stay in ps2_rx_buf.

Test Plan:
- Send byte 0x1C (odd parity bit 0, stop 1), ps2c period 2000 cycles -> rx_done_tick once, 1 cycle after the final fall; valid = 1, dout = 0x1C, count = 1; rd_en for one cycle -> valid = 0, dout = 0.
- Send 0x5A with parity bit flipped -> parity_err pulses once, count stays 0; then send 0xF0 with stop bit 0 -> frame_err once, FIFO untouched.
- FIFO_DEPTH = 4: send 5 good bytes 0x01..0x05 with no reads -> full = 1 after the 4th, overflow = 1 after the 5th; reads return 0x01..0x04; err_clr -> overflow = 0.
- Inject 3-cycle low glitches on ps2c with FILTER_LEN = 8 -> no falls detected, FSM stays IDLE; then stop ps2c after 4 bits with TIMEOUT_CYC = 100 -> timeout_err exactly 100 cycles after the last fall, FSM back to IDLE.
- Assert reset_n low mid-frame after 5 bits -> all outputs 0 immediately; after release a full clean frame 0xAA is received correctly. Also with rx_en = 0: start edges are ignored; dropping rx_en mid-frame still completes that frame.
- With the FIFO full and valid, a good byte arrives in the same cycle as rd_en -> byte accepted, count stays FIFO_DEPTH, no overflow.
